background_renderer_anim: RTL

//  Animated, parametrised background layer for the Footsies VGA pipeline.
//  Per pixel, outputs an RGB332 colour from ground, a moving sun and a sky that cycles DAY->DUSK->NIGHT.

---
 rtl/footsies_video_pkg.sv | 21 ++
 rtl/bg_scene_sequencer.sv | 122 ++++++++++++
 rtl/background_renderer_anim.sv | 98 +++++++++
 3 files changed

// File: rtl/footsies_video_pkg.sv
// Shared video definitions for the Footsies VGA pipeline:
// RGB332 colour constants, sky-state encoding and coordinate width.
`timescale 1ns/1ps
package footsies_video_pkg;

    localparam int COORD_W = 10;

    localparam logic [7:0] RGB_SKY_DAY   = 8'hB0;
    localparam logic [7:0] RGB_SKY_DUSK  = 8'hA0;
    localparam logic [7:0] RGB_SKY_NIGHT = 8'h02;
    localparam logic [7:0] RGB_GROUND    = 8'h00;
    localparam logic [7:0] RGB_SUN       = 8'hE0;
    localparam logic [7:0] RGB_BLANK     = 8'h00;

    typedef enum logic [1:0] {
        SKY_DAY   = 2'd0,
        SKY_DUSK  = 2'd1,
        SKY_NIGHT = 2'd2
    } sky_state_t;

endpackage

// File: rtl/bg_scene_sequencer.sv
// Frame-rate scene sequencer: sky state (DAY/DUSK/NIGHT), sun position,
// frame divider, night counter and, when SCREEN_SHAKE_EN is defined,
// the screen-shake counter. Everything advances only on frame_tick.
`timescale 1ns/1ps
module bg_scene_sequencer
    import footsies_video_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int SUN_SIZE        = 40,
    parameter int SUN_X_START     = 500,
    parameter int SUN_STEP_FRAMES = 8,
    parameter int DUSK_X          = 200,
    parameter int NIGHT_FRAMES    = 64,
    parameter int SHAKE_FRAMES    = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               freeze,
    input  logic               hit_pulse,
    output sky_state_t         state,
    output logic [COORD_W-1:0] sun_x,
    output logic               shake_odd
);

    localparam int FD_W = (SUN_STEP_FRAMES > 1) ? $clog2(SUN_STEP_FRAMES) : 1;
    localparam int NC_W = (NIGHT_FRAMES > 1) ? $clog2(NIGHT_FRAMES) : 1;
    localparam logic [FD_W-1:0]    FD_LAST = FD_W'(SUN_STEP_FRAMES - 1);
    localparam logic [NC_W-1:0]    NC_LAST = NC_W'(NIGHT_FRAMES - 1);
    localparam logic [COORD_W-1:0] DUSK_LIM = COORD_W'(DUSK_X);
    localparam logic [COORD_W-1:0] SUN_RESTART = COORD_W'(H_ACTIVE - SUN_SIZE);

    sky_state_t         state_nxt;
    logic [COORD_W-1:0] sun_x_nxt;
    logic [COORD_W-1:0] sun_dec;
    logic [FD_W-1:0]    frame_div, frame_div_nxt;
    logic [NC_W-1:0]    night_cnt, night_cnt_nxt;
    logic               advance;
    logic               step;

    // Scene state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SKY_DAY;
            sun_x     <= COORD_W'(SUN_X_START);
            frame_div <= '0;
            night_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sun_x     <= sun_x_nxt;
            frame_div <= frame_div_nxt;
            night_cnt <= night_cnt_nxt;
        end
    end

    // Next-state logic: the sun walks left one pixel per step, dusk starts
    // once it crosses DUSK_X, night follows the step after it reaches x=0
    always_comb begin
        state_nxt     = state;
        sun_x_nxt     = sun_x;
        frame_div_nxt = frame_div;
        night_cnt_nxt = night_cnt;
        advance       = frame_tick && !freeze;
        step          = (frame_div == FD_LAST);
        sun_dec       = sun_x - COORD_W'(1);
        if (advance) begin
            case (state)
                SKY_DAY: begin
                    frame_div_nxt = step ? '0 : frame_div + FD_W'(1);
                    if (step) begin
                        sun_x_nxt = sun_dec;
                        if (sun_dec < DUSK_LIM) state_nxt = SKY_DUSK;
                    end
                end
                SKY_DUSK: begin
                    frame_div_nxt = step ? '0 : frame_div + FD_W'(1);
                    if (step) begin
                        if (sun_x == '0) begin
                            state_nxt     = SKY_NIGHT;
                            night_cnt_nxt = '0;
                        end else begin
                            sun_x_nxt = sun_dec;
                        end
                    end
                end
                SKY_NIGHT: begin
                    if (night_cnt == NC_LAST) begin
                        state_nxt     = SKY_DAY;
                        sun_x_nxt     = SUN_RESTART;
                        frame_div_nxt = '0;
                    end else begin
                        night_cnt_nxt = night_cnt + NC_W'(1);
                    end
                end
                default: state_nxt = SKY_DAY;
            endcase
        end
    end

`ifdef SCREEN_SHAKE_EN
    localparam int SC_W = $clog2(SHAKE_FRAMES + 1);
    logic [SC_W-1:0] shake_cnt;

    // Shake counter: a hit reloads it, each frame counts it down, pause ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shake_cnt <= '0;
        end else if (hit_pulse) begin
            shake_cnt <= SC_W'(SHAKE_FRAMES);
        end else if (frame_tick && shake_cnt != '0) begin
            shake_cnt <= shake_cnt - SC_W'(1);
        end
    end

    assign shake_odd = shake_cnt[0];
`else
    logic unused_hit;
    assign unused_hit = hit_pulse;
    assign shake_odd  = 1'b0;
`endif

endmodule

// File: rtl/background_renderer_anim.sv
// Animated background layer: registered per-pixel compositor
// (ground > sun > sky) driven by bg_scene_sequencer.
// Optional feature macro: SCREEN_SHAKE_EN (ground lift on landed hits).
`timescale 1ns/1ps
module background_renderer_anim
    import footsies_video_pkg::*;
#(
    parameter int         H_ACTIVE        = 640,
    parameter int         GROUND_Y        = 400,
    parameter int         SUN_SIZE        = 40,
    parameter int         SUN_Y           = 60,
    parameter int         SUN_X_START     = 500,
    parameter int         SUN_STEP_FRAMES = 8,
    parameter int         DUSK_X          = 200,
    parameter int         NIGHT_FRAMES    = 64,
    parameter logic [7:0] SKY_DAY_C       = RGB_SKY_DAY,
    parameter logic [7:0] SKY_DUSK_C      = RGB_SKY_DUSK,
    parameter logic [7:0] SKY_NIGHT_C     = RGB_SKY_NIGHT,
    parameter logic [7:0] GROUND_C        = RGB_GROUND,
    parameter logic [7:0] SUN_C           = RGB_SUN,
    parameter int         SHAKE_FRAMES    = 12,
    parameter int         SHAKE_AMP       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               freeze,
    input  logic               hit_pulse,
    input  logic               video_on,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic [7:0]         bg_color,
    output logic               bg_valid
);

    sky_state_t         state;
    logic [COORD_W-1:0] sun_x;
    logic               shake_odd;
    logic [COORD_W-1:0] ground_y;
    logic [COORD_W:0]   px_w, py_w, sx_w;
    logic               in_ground, in_sun;
    logic [7:0]         sky_c;
    logic [7:0]         color_p0;

    bg_scene_sequencer #(
        .H_ACTIVE        (H_ACTIVE),
        .SUN_SIZE        (SUN_SIZE),
        .SUN_X_START     (SUN_X_START),
        .SUN_STEP_FRAMES (SUN_STEP_FRAMES),
        .DUSK_X          (DUSK_X),
        .NIGHT_FRAMES    (NIGHT_FRAMES),
        .SHAKE_FRAMES    (SHAKE_FRAMES)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .freeze     (freeze),
        .hit_pulse  (hit_pulse),
        .state      (state),
        .sun_x      (sun_x),
        .shake_odd  (shake_odd)
    );

    // Pixel classification and colour selection; sums kept 11-bit so the
    // sun box never wraps near the right edge
    always_comb begin
        ground_y  = shake_odd ? COORD_W'(GROUND_Y - SHAKE_AMP) : COORD_W'(GROUND_Y);
        px_w      = {1'b0, pixel_x};
        py_w      = {1'b0, pixel_y};
        sx_w      = {1'b0, sun_x};
        in_ground = (pixel_y >= ground_y);
        in_sun    = (state != SKY_NIGHT)
                    && (sx_w < px_w) && (px_w < sx_w + (COORD_W+1)'(SUN_SIZE))
                    && ((COORD_W+1)'(SUN_Y) < py_w)
                    && (py_w < (COORD_W+1)'(SUN_Y + SUN_SIZE));
        case (state)
            SKY_DUSK:  sky_c = SKY_DUSK_C;
            SKY_NIGHT: sky_c = SKY_NIGHT_C;
            default:   sky_c = SKY_DAY_C;
        endcase
        if (!video_on)      color_p0 = RGB_BLANK;
        else if (in_ground) color_p0 = GROUND_C;
        else if (in_sun)    color_p0 = SUN_C;
        else                color_p0 = sky_c;
    end

    // Output register: one cycle of latency from pixel coordinates to colour
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_color <= RGB_BLANK;
            bg_valid <= 1'b0;
        end else begin
            bg_color <= color_p0;
            bg_valid <= video_on;
        end
    end

endmodule
